// File: rtl/pcie_pkg.sv
// Shared constants and types for the PCIe receive path.
package pcie_pkg;

   localparam int unsigned QW_PER_TAG    = 64;
   localparam int unsigned INDEX_BITS    = 6;
   localparam int unsigned PCIE_TAG_BITS = 8;
   localparam int unsigned DATA_BITS     = 64;

   typedef enum logic {
      IDLE,
      READ
   } drain_state_e;

   typedef struct packed {
      logic                 last;
      logic [DATA_BITS-1:0] data;
   } out_beat_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with registered read (1-cycle latency) for block RAM inference.
module sdp_ram #(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned ADDR_BITS = 11
) (
   input  logic                 clock,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WIDTH-1:0]     wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [WIDTH-1:0]     rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/pcie_rx_reorder.sv
// Per-tag completion reorder buffer: collects out-of-order qwords into slots and
// streams whole slots out in tag-allocation order; also allocates request tags.
module pcie_rx_reorder
   import pcie_pkg::*;
#(
   parameter int unsigned TAG_BITS = 5
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     completion_valid,
   input  logic [PCIE_TAG_BITS-1:0] completion_tag,
   input  logic [INDEX_BITS-1:0]    completion_index,
   input  logic [DATA_BITS-1:0]     data,
   output logic                     tag_ready,
   input  logic                     tag_valid,
   output logic [TAG_BITS-1:0]      tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_BITS-1:0]     out_data,
   output logic                     out_last,
   output logic                     error
);

   localparam int unsigned NUM_SLOTS = 1 << TAG_BITS;
   localparam int unsigned PTR_BITS  = TAG_BITS + 1;
   localparam int unsigned ADDR_BITS = TAG_BITS + INDEX_BITS;
   localparam int unsigned CNT_BITS  = INDEX_BITS + 1;

   logic [PTR_BITS-1:0]   tail, head, occupancy;
   logic [TAG_BITS-1:0]   head_slot;
   logic [CNT_BITS-1:0]   cnt [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]  done;
   drain_state_e          state, state_next;
   logic [INDEX_BITS-1:0] rd_idx, rd_idx_next;
   logic                  rd_en, retire, rd_space;
   logic                  rd_pending, rd_last;
   logic [DATA_BITS-1:0]  ram_rd_data;

   logic [TAG_BITS-1:0]   cpl_slot, cpl_offset;
   logic                  cpl_hi_ok, cpl_in_flight, cpl_full, cpl_accept, cpl_reject;

   out_beat_t             fifo_mem [2];
   logic                  wr_ptr, rd_ptr, push, pop;
   logic [1:0]            fifo_cnt;

   assign occupancy = tail - head;
   assign head_slot = head[TAG_BITS-1:0];
   assign tag_ready = occupancy != PTR_BITS'(NUM_SLOTS);
   assign tag       = tail[TAG_BITS-1:0];

   // Completion acceptance: tag range, slot in flight, slot not yet full.
   assign cpl_slot      = completion_tag[TAG_BITS-1:0];
   assign cpl_offset    = cpl_slot - head_slot;
   assign cpl_hi_ok     = completion_tag[PCIE_TAG_BITS-1:TAG_BITS] == '0;
   assign cpl_in_flight = {1'b0, cpl_offset} < occupancy;
   assign cpl_full      = cnt[cpl_slot] == CNT_BITS'(QW_PER_TAG);
   assign cpl_accept    = completion_valid && cpl_hi_ok && cpl_in_flight && !cpl_full;
   assign cpl_reject    = completion_valid && !cpl_accept;

   // A read may issue only if the FIFO can hold it plus any read still in the RAM.
   assign pop      = out_valid && out_ready;
   assign push     = rd_pending;
   assign rd_space = (3'(fifo_cnt) + 3'(rd_pending)) < (3'd2 + 3'(pop));

   // Drain: reads of index 0 issue straight from IDLE so done slots stream back to back.
   always_comb begin
      state_next  = state;
      rd_idx_next = rd_idx;
      rd_en       = 1'b0;
      retire      = 1'b0;
      case (state)
         IDLE: begin
            if (done[head_slot] && rd_space) begin
               rd_en       = 1'b1;
               rd_idx_next = INDEX_BITS'(1);
               state_next  = READ;
            end
         end
         READ: begin
            if (rd_space) begin
               rd_en = 1'b1;
               if (rd_idx == INDEX_BITS'(QW_PER_TAG - 1)) begin
                  retire      = 1'b1;
                  rd_idx_next = '0;
                  state_next  = IDLE;
               end else begin
                  rd_idx_next = rd_idx + INDEX_BITS'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tail       <= '0;
         head       <= '0;
         state      <= IDLE;
         rd_idx     <= '0;
         rd_pending <= 1'b0;
         rd_last    <= 1'b0;
         error      <= 1'b0;
         done       <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_cnt   <= '0;
         for (int s = 0; s < NUM_SLOTS; s++) cnt[s] <= '0;
      end else begin
         if (tag_valid && tag_ready) tail <= tail + PTR_BITS'(1);
         if (retire) head <= head + PTR_BITS'(1);
         state      <= state_next;
         rd_idx     <= rd_idx_next;
         rd_pending <= rd_en;
         rd_last    <= rd_en && (rd_idx == INDEX_BITS'(QW_PER_TAG - 1));
         if (cpl_reject) error <= 1'b1;
         // Retire wins; a slot being drained is full so it cannot also take a write.
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (retire && head_slot == TAG_BITS'(s)) begin
               cnt[s]  <= '0;
               done[s] <= 1'b0;
            end else begin
               if (cpl_accept && cpl_slot == TAG_BITS'(s)) cnt[s] <= cnt[s] + CNT_BITS'(1);
               if (cnt[s] == CNT_BITS'(QW_PER_TAG)) done[s] <= 1'b1;
            end
         end
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr] <= '{last: rd_last, data: ram_rd_data};
   end

   assign out_valid = fifo_cnt != '0;
   assign out_data  = fifo_mem[rd_ptr].data;
   assign out_last  = fifo_mem[rd_ptr].last && out_valid;

   sdp_ram #(
      .WIDTH     (DATA_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clock   (clock),
      .wr_en   (cpl_accept),
      .wr_addr ({cpl_slot, completion_index}),
      .wr_data (data),
      .rd_en   (rd_en),
      .rd_addr ({head_slot, rd_idx}),
      .rd_data (ram_rd_data)
   );

endmodule

// File: tb/tb_pcie_rx_reorder.sv
// Self-checking bench for pcie_rx_reorder: slot model feeds an expected-output queue.
module tb_pcie_rx_reorder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        completion_valid;
   logic [7:0]  completion_tag;
   logic [5:0]  completion_index;
   logic [63:0] data;
   logic        tag_ready;
   logic        tag_valid;
   logic [4:0]  tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;
   logic        error;

   pcie_rx_reorder #(.TAG_BITS(5)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .completion_valid (completion_valid),
      .completion_tag   (completion_tag),
      .completion_index (completion_index),
      .data             (data),
      .tag_ready        (tag_ready),
      .tag_valid        (tag_valid),
      .tag              (tag),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_last         (out_last),
      .error            (error)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          failures = 0;
   logic [64:0] exp_q [$];
   logic        mon_en = 1'b0;
   logic        bp_en = 1'b0;

   logic [5:0]  m_tail, m_head;
   int          m_cnt [32];
   logic [63:0] m_data [32][64];

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Model: move every completed slot at the head into the expected queue, in order.
   task automatic push_ready_slots();
      while (m_tail != m_head && m_cnt[m_head[4:0]] == 64) begin
         for (int i = 0; i < 64; i++) exp_q.push_back({i == 63, m_data[m_head[4:0]][i]});
         m_cnt[m_head[4:0]] = 0;
         m_head = m_head + 6'd1;
      end
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      reset_n = 1'b0;
      completion_valid = 1'b0;
      completion_tag = '0;
      completion_index = '0;
      data = '0;
      tag_valid = 1'b0;
      step();
      step();
      exp_q.delete();
      m_tail = '0;
      m_head = '0;
      for (int s = 0; s < 32; s++) m_cnt[s] = 0;
      reset_n = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic check_idle_outputs();
      check_val("rst_tag_ready", 64'(tag_ready), 64'd1);
      check_val("rst_tag", 64'(tag), 64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_out_last", 64'(out_last), 64'd0);
      check_val("rst_error", 64'(error), 64'd0);
   endtask

   task automatic alloc(input int n);
      for (int i = 0; i < n; i++) begin
         logic rdy;
         rdy = (m_tail - m_head) != 6'd32;
         check_val("alloc_tag", 64'(tag), 64'(m_tail[4:0]));
         check_val("alloc_ready", 64'(tag_ready), 64'(rdy));
         tag_valid = 1'b1;
         step();
         tag_valid = 1'b0;
         if (rdy) m_tail = m_tail + 6'd1;
      end
   endtask

   task automatic send(input logic [7:0] t, input logic [5:0] idx, input logic [63:0] d);
      logic [4:0] s, off;
      logic       acc;
      s = t[4:0];
      off = s - m_head[4:0];
      acc = (t[7:5] == 3'd0) && ({1'b0, off} < (m_tail - m_head)) && (m_cnt[s] != 64);
      completion_valid = 1'b1;
      completion_tag = t;
      completion_index = idx;
      data = d;
      step();
      completion_valid = 1'b0;
      if (acc) begin
         m_data[s][idx] = d;
         m_cnt[s]++;
         push_ready_slots();
      end
   endtask

   task automatic fill_slot(input logic [4:0] s, input logic [63:0] base, input logic shuffle);
      int perm [64];
      for (int i = 0; i < 64; i++) perm[i] = i;
      if (shuffle) begin
         for (int i = 63; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
         end
      end
      for (int i = 0; i < 64; i++) send({3'd0, s}, 6'(perm[i]), base | 64'(perm[i]));
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step();
      check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
      step();
      step();
   endtask

   // Output monitor: every valid beat must match the queue front; pop on handshake.
   initial begin
      forever begin
         @(negedge clock);
         if (mon_en && out_valid) begin
            if (exp_q.size() == 0) begin
               check_val("spurious_out", out_data, 64'hdead_0000_0000_0000);
            end else begin
               logic [64:0] e;
               e = exp_q[0];
               check_val(out_ready ? "out_data" : "hold_data", out_data, e[63:0]);
               check_val(out_ready ? "out_last" : "hold_last", 64'(out_last), 64'(e[64]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      do_reset();
      check_idle_outputs();

      // In-order fill with first-output latency
      alloc(1);
      fill_slot(5'd0, 64'd0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         step();
         check_val("latency_valid", 64'(out_valid), 64'(k == 3));
      end
      wait_drain();

      // Out-of-order slot completion
      do_reset();
      alloc(3);
      fill_slot(5'd2, {32'd1, 16'd2, 16'd0}, 1'b1);
      fill_slot(5'd0, {32'd1, 16'd0, 16'd0}, 1'b1);
      fill_slot(5'd1, {32'd1, 16'd1, 16'd0}, 1'b1);
      wait_drain();

      // Full and wrap
      do_reset();
      alloc(32);
      check_val("full_ready", 64'(tag_ready), 64'd0);
      alloc(1);
      check_val("full_ignored_tag", 64'(tag), 64'd0);
      fill_slot(5'd0, {32'd2, 16'd0, 16'd0}, 1'b1);
      wait_drain();
      check_val("recycle_ready", 64'(tag_ready), 64'd1);
      check_val("recycle_tag", 64'(tag), 64'd0);
      for (int it = 1; it <= 40; it++) begin
         alloc(1);
         check_val("wrap_full", 64'(tag_ready), 64'd0);
         fill_slot(m_head[4:0], {32'(it + 2), 16'(m_head[4:0]), 16'd0}, 1'b1);
         wait_drain();
      end

      // Backpressure across two slots
      do_reset();
      alloc(2);
      bp_en = 1'b1;
      fill_slot(5'd1, {32'd50, 16'd1, 16'd0}, 1'b1);
      fill_slot(5'd0, {32'd50, 16'd0, 16'd0}, 1'b1);
      wait_drain();
      bp_en = 1'b0;
      step();

      // Errors: upper tag bits set
      do_reset();
      alloc(4);
      check_val("err_clear", 64'(error), 64'd0);
      send(8'h40, 6'd0, 64'hbad0);
      check_val("err_tag_hi", 64'(error), 64'd1);
      fill_slot(5'd0, {32'd60, 16'd0, 16'd0}, 1'b1);
      wait_drain();

      // Errors: tag not in flight
      do_reset();
      alloc(4);
      send(8'h05, 6'd0, 64'hbad1);
      check_val("err_not_in_flight", 64'(error), 64'd1);

      // Errors: 65th qword to a full slot that is not yet draining
      do_reset();
      alloc(4);
      fill_slot(5'd1, {32'd70, 16'd1, 16'd0}, 1'b1);
      check_val("err_before_65th", 64'(error), 64'd0);
      send(8'h01, 6'd5, 64'hbad2);
      check_val("err_65th", 64'(error), 64'd1);
      fill_slot(5'd0, {32'd70, 16'd0, 16'd0}, 1'b1);
      fill_slot(5'd2, {32'd70, 16'd2, 16'd0}, 1'b1);
      fill_slot(5'd3, {32'd70, 16'd3, 16'd0}, 1'b1);
      wait_drain();

      // Reset during slot output, then a fresh fill
      do_reset();
      alloc(2);
      fill_slot(5'd0, {32'd80, 16'd0, 16'd0}, 1'b1);
      for (int i = 0; i < 200 && exp_q.size() > 40; i++) step();
      check_val("mid_stream_reached", 64'(exp_q.size() <= 40), 64'd1);
      mon_en = 1'b0;
      reset_n = 1'b0;
      step();
      check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check_val("mid_rst_tag_ready", 64'(tag_ready), 64'd1);
      check_val("mid_rst_tag", 64'(tag), 64'd0);
      check_val("mid_rst_error", 64'(error), 64'd0);
      do_reset();
      check_idle_outputs();
      alloc(1);
      fill_slot(5'd0, {32'd90, 16'd0, 16'd0}, 1'b1);
      wait_drain();
      check_val("final_error", 64'(error), 64'd0);
      check_val("final_ready", 64'(tag_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
